// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaled counter (edge or center aligned),
// per-channel double-buffered duty with edge-triggered step and direct load.
module pwm_multi_ch #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8,
  parameter int STEP       = 1,
  parameter int RESET_DUTY = 2 ** (WIDTH - 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic                      center_mode,
  input  logic [CHANNELS-1:0]       duty_inc,
  input  logic [CHANNELS-1:0]       duty_dec,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  output logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       PWM_out,
  output logic                      period_start
);

  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] RST_D  = WIDTH'(RESET_DUTY);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic rst_meta_q, rst_sync_q;

  logic [PRESCALE_W-1:0]           psc_q, psc_d;
  logic                            tick;
  logic [WIDTH-1:0]                cnt_q, cnt_d;
  dir_e                            dir_q, dir_d;
  logic                            mode_q, mode_d;
  logic                            boundary;
  logic [CHANNELS-1:0][WIDTH-1:0]  pend_q, pend_d, act_q, act_d;
  logic [CHANNELS-1:0]             inc_prev_q, dec_prev_q, inc_rise, dec_rise;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic                            period_start_q;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] s;
    s = {1'b0, v} + STEP_X;
    return (s > {1'b0, MAX}) ? MAX : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] s;
    s = {1'b0, v} - STEP_X;
    return ({1'b0, v} < STEP_X) ? '0 : s[WIDTH-1:0];
  endfunction

  // Assert asynchronously, release two clocks after rst rises.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign tick     = en && (psc_q == prescale);
  assign inc_rise = duty_inc & ~inc_prev_q;
  assign dec_rise = duty_dec & ~dec_prev_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    psc_d    = '0;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    boundary = 1'b0;
    if (en && !tick) psc_d = psc_q + PRESCALE_W'(1);
    if (!en) begin
      cnt_d  = '0;
      dir_d  = DIR_UP;
      mode_d = center_mode;
    end else if (tick) begin
      if (!mode_q) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == MAX) begin
          cnt_d = cnt_q - WIDTH'(1);
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
      // Reaching zero while running is the period boundary in both modes.
      if (cnt_d == '0) begin
        dir_d    = DIR_UP;
        mode_d   = center_mode;
        boundary = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    pwm_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load[i])                       pend_d[i] = load_val[i*WIDTH +: WIDTH];
      else if (inc_rise[i] && !dec_rise[i]) pend_d[i] = sat_inc(pend_q[i]);
      else if (dec_rise[i] && !inc_rise[i]) pend_d[i] = sat_dec(pend_q[i]);
      if (!en || boundary) act_d[i] = pend_q[i];
      pwm_d[i] = en && (cnt_q < act_q[i]);
    end
  end

  // NOTE: the per-channel duty registers are plain flops, so they take a reset value;
  // a RAM-style array would not be reset this way.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      psc_q          <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      mode_q         <= 1'b0;
      pend_q         <= {CHANNELS{RST_D}};
      act_q          <= {CHANNELS{RST_D}};
      inc_prev_q     <= '0;
      dec_prev_q     <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      psc_q          <= psc_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      pend_q         <= pend_d;
      act_q          <= act_d;
      inc_prev_q     <= duty_inc;
      dec_prev_q     <= duty_dec;
      pwm_q          <= pwm_d;
      period_start_q <= boundary;
    end
  end

  assign duty         = act_q;
  assign PWM_out      = pwm_q;
  assign period_start = period_start_q;

endmodule
